gs_sweep_ctrl: RTL and testbench
================================

# gs_sweep_ctrl

Sequencer for the Gauss-Seidel solver datapath. It accepts 16 right-hand-side samples (b) from the host and drives the load enable of the b/x register file. It then runs a fixed number of Gauss-Seidel sweeps by issuing one row per slot to the processing element and strobing its write-back. Finally it streams the 16 solved x values out under a valid/ready handshake. It sits between the host interface and the register file / PE pipeline and owns all phase, row and iteration counting.

## Interface
- N_ROW, 16: unknowns per system; row counter width = clog2(N_ROW).
- N_ITER, 16: full sweeps per solve, ≥1; iteration counter width = clog2(N_ITER+1).
- PE_LAT, 2: PE latency in cycles from row issue to result valid, 0..7.

- clk_in  input  1  clock, all state on rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- in_valid_in  input  1  host b sample present this cycle.
- out_ready_in  input  1  host accepts x sample.
- b_en_out  output  1  register-file load enable; accepted b sample shifts in.
- issue_out  output  1  PE row issue strobe.
- wb_en_out  output  1  PE result write-back / x shift enable.
- row_out  output  clog2(N_ROW)  current row index (load, solve or output).
- iter_out  output  clog2(N_ITER+1)  completed sweeps.
- out_valid_out  output  1  x sample on register-file head is valid.
- busy_out  output  1  high in every state except IDLE.
- done_out  output  1  one-cycle pulse at solve completion.

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, OUTPUT, DONE.
- IDLE:
  - row = 0, iter = 0.
  - in_valid_in=1 → b_en_out=1 that cycle, row ← 1, go to LOAD.
  - Exception, N_ROW=1: go straight to ISSUE with row ← 0.
- LOAD:
  - b_en_out = in_valid_in, combinational.
  - Each accepted sample increments row.
  - Gaps in in_valid_in hold all state.
  - Accepting the sample with row=N_ROW-1 → row ← 0, go to ISSUE.
- ISSUE:
  - issue_out=1 for exactly one cycle with row_out = row being solved.
  - PE_LAT=0: wb_en_out=1 in the same cycle, then advance the row.
  - PE_LAT>0: go to WAIT with wait counter ← PE_LAT.
- WAIT:
  - Wait counter decrements each cycle.
  - wb_en_out=1 on the cycle the counter equals 1, then advance the row.
  - No new issue while waiting; Gauss-Seidel needs the freshly written x.
- Advance the row:
  - row<N_ROW-1 → row+1, go to ISSUE.
  - Otherwise row ← 0 and iter+1.
  - New iter = N_ITER → go to OUTPUT; else go to ISSUE.
- OUTPUT:
  - out_valid_out=1.
  - Handshake when out_valid_out & out_ready_in: wb_en_out=1 to rotate the x file, row+1.
  - out_ready_in low holds everything.
  - Handshake at row=N_ROW-1 → go to DONE.
- DONE:
  - done_out=1 for one cycle, then IDLE.
  - row and iter clear on entry to IDLE.
- in_valid_in is ignored in ISSUE, WAIT, OUTPUT and DONE; no back-pressure to the host.
- Counters never wrap past their terminal values. The row is compared against N_ROW-1, never overflowed.

## Timing
- Reset, asynchronous, any state:
  - state=IDLE, row=0, iter=0, wait counter=0.
  - b_en_out, issue_out, wb_en_out, out_valid_out, busy_out, done_out all 0.
  - Takes effect immediately, without a clock. An in-progress solve is discarded with no done_out.
- All strobes are Moore except b_en_out (gated by in_valid_in) and the OUTPUT-phase wb_en_out (gated by out_ready_in).
- Load takes N_ROW accepted samples. The first ISSUE occurs the cycle after the last accepted sample.
- Row period is PE_LAT+1 cycles.
- Solve phase lasts N_ITER·N_ROW·(PE_LAT+1) cycles.
- wb_en_out follows its issue_out by exactly PE_LAT cycles.
- out_valid_out rises the cycle after the final wb_en_out of the last sweep.
- With out_ready_in held high, OUTPUT lasts N_ROW cycles and done_out follows one cycle later.
- busy_out rises the cycle after the first accepted b and falls the cycle after done_out.

## Test plan
- Reset mid-WAIT (PE_LAT=2) → all outputs 0 in the same cycle; after release, row_out=0, iter_out=0, busy_out=0.
- Load 16 b with in_valid_in held high, PE_LAT=0, N_ITER=2 → b_en_out high 16 cycles, then 32 consecutive cycles of issue_out=wb_en_out=1 with row_out 0..15 twice, then out_valid_out.
- PE_LAT=3, N_ITER=1 → issue_out on cycles t, t+4, t+8, …; wb_en_out on t+3, t+7, …; 64 solve cycles; iter_out reaches 1.
- in_valid_in toggled 1,0,1,0… during LOAD → row_out advances only on high cycles; 32 cycles to finish load; no issue_out before the 16th sample.
- OUTPUT with out_ready_in pattern 1,0,0,1… → row_out and wb_en_out step only on ready cycles; done_out pulses once after the 16th handshake; in_valid_in=1 during OUTPUT produces no b_en_out.

Source files
------------

// File: rtl/gs_sweep_ctrl.sv
// Gauss-Seidel solve sequencer: loads N_ROW b samples, runs N_ITER sweeps of
// one-row-at-a-time PE issue/write-back, then streams the solved x values out.
module gs_sweep_ctrl #(
  parameter int N_ROW  = 16,
  parameter int N_ITER = 16,
  parameter int PE_LAT = 2,
  localparam int RW = (N_ROW > 1) ? $clog2(N_ROW) : 1,
  localparam int IW = (N_ITER > 0) ? $clog2(N_ITER + 1) : 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          in_valid_in,
  input  logic          out_ready_in,
  output logic          b_en_out,
  output logic          issue_out,
  output logic          wb_en_out,
  output logic [RW-1:0] row_out,
  output logic [IW-1:0] iter_out,
  output logic          out_valid_out,
  output logic          busy_out,
  output logic          done_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_OUTPUT,
    S_DONE
  } state_t;

  localparam logic [RW-1:0] ROW_LAST  = RW'(N_ROW - 1);
  localparam logic [IW-1:0] ITER_LAST = IW'(N_ITER - 1);
  localparam logic [2:0]    WAIT_INIT = 3'(PE_LAT);

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic          adv;

  // State, row, iteration and PE wait counters
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      iter_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      iter_q  <= iter_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state and strobe decode; a completed row write-back funnels into a
  // single shared row/sweep advance after the case
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    iter_d        = iter_q;
    wcnt_d        = wcnt_q;
    adv           = 1'b0;
    b_en_out      = 1'b0;
    issue_out     = 1'b0;
    wb_en_out     = 1'b0;
    out_valid_out = 1'b0;
    done_out      = 1'b0;

    case (state_q)
      S_IDLE: begin
        row_d  = '0;
        iter_d = '0;
        if (in_valid_in) begin
          b_en_out = 1'b1;
          if (N_ROW == 1) begin
            state_d = S_ISSUE;
          end else begin
            row_d   = RW'(1);
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        b_en_out = in_valid_in;
        if (in_valid_in) begin
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = S_ISSUE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end

      S_ISSUE: begin
        issue_out = 1'b1;
        if (PE_LAT == 0) begin
          wb_en_out = 1'b1;
          adv       = 1'b1;
        end else begin
          wcnt_d  = WAIT_INIT;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        wcnt_d = wcnt_q - 1'b1;
        if (wcnt_q == 3'd1) begin
          wb_en_out = 1'b1;
          adv       = 1'b1;
        end
      end

      S_OUTPUT: begin
        out_valid_out = 1'b1;
        if (out_ready_in) begin
          wb_en_out = 1'b1;
          if (row_q == ROW_LAST) begin
            state_d = S_DONE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        done_out = 1'b1;
        row_d    = '0;
        iter_d   = '0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (adv) begin
      if (row_q != ROW_LAST) begin
        row_d   = row_q + 1'b1;
        state_d = S_ISSUE;
      end else begin
        row_d   = '0;
        iter_d  = iter_q + 1'b1;
        state_d = (iter_q == ITER_LAST) ? S_OUTPUT : S_ISSUE;
      end
    end
  end

  assign row_out  = row_q;
  assign iter_out = iter_q;
  assign busy_out = (state_q != S_IDLE);

endmodule

// File: tb/tb_gs_sweep_ctrl.sv
// Scoreboard bench for gs_sweep_ctrl: three instances with different sweep
// and latency settings, exercised one at a time.
module tb_gs_sweep_ctrl;

  typedef struct packed {
    logic [19:0] cyc;
    logic [1:0]  d;
    logic        b;
    logic        is;
    logic        wb;
    logic        ov;
    logic        dn;
    logic        bz;
    logic [3:0]  row;
    logic [4:0]  it;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] iv;
  logic [2:0] rdy;

  logic       a_b, a_is, a_wb, a_ov, a_bz, a_dn;
  logic [3:0] a_row;
  logic [1:0] a_it;
  logic       b_b, b_is, b_wb, b_ov, b_bz, b_dn;
  logic [3:0] b_row;
  logic [1:0] b_it;
  logic       c_b, c_is, c_wb, c_ov, c_bz, c_dn;
  logic [3:0] c_row;
  logic [0:0] c_it;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  bit  fin = 1'b0;
  ev_t qe[$];
  ev_t qs[$];

  gs_sweep_ctrl #(.N_ROW(16), .N_ITER(2), .PE_LAT(2)) u_a (
    .clk_in(clk), .rst_in(rst), .in_valid_in(iv[0]), .out_ready_in(rdy[0]),
    .b_en_out(a_b), .issue_out(a_is), .wb_en_out(a_wb), .row_out(a_row),
    .iter_out(a_it), .out_valid_out(a_ov), .busy_out(a_bz), .done_out(a_dn));

  gs_sweep_ctrl #(.N_ROW(16), .N_ITER(2), .PE_LAT(0)) u_b (
    .clk_in(clk), .rst_in(rst), .in_valid_in(iv[1]), .out_ready_in(rdy[1]),
    .b_en_out(b_b), .issue_out(b_is), .wb_en_out(b_wb), .row_out(b_row),
    .iter_out(b_it), .out_valid_out(b_ov), .busy_out(b_bz), .done_out(b_dn));

  gs_sweep_ctrl #(.N_ROW(16), .N_ITER(1), .PE_LAT(3)) u_c (
    .clk_in(clk), .rst_in(rst), .in_valid_in(iv[2]), .out_ready_in(rdy[2]),
    .b_en_out(c_b), .issue_out(c_is), .wb_en_out(c_wb), .row_out(c_row),
    .iter_out(c_it), .out_valid_out(c_ov), .busy_out(c_bz), .done_out(c_dn));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int c, input int d, input bit b, input bit is,
                             input bit wb, input bit ov, input bit dn, input bit bz,
                             input int row, input int it);
    ev_t e;
    e.cyc = 20'(c);
    e.d   = 2'(d);
    e.b   = b;
    e.is  = is;
    e.wb  = wb;
    e.ov  = ov;
    e.dn  = dn;
    e.bz  = bz;
    e.row = 4'(row);
    e.it  = 5'(it);
    return e;
  endfunction

  function automatic ev_t obs(input int d, input int c);
    case (d)
      0:       return mk(c, 0, a_b, a_is, a_wb, a_ov, a_dn, a_bz, int'(a_row), int'(a_it));
      1:       return mk(c, 1, b_b, b_is, b_wb, b_ov, b_dn, b_bz, int'(b_row), int'(b_it));
      default: return mk(c, 2, c_b, c_is, c_wb, c_ov, c_dn, c_bz, int'(c_row), int'(c_it));
    endcase
  endfunction

  function automatic string fmt(input ev_t e);
    return $sformatf("cyc=%0d dut=%0d b_en=%0b issue=%0b wb=%0b ovalid=%0b done=%0b busy=%0b row=%0d iter=%0d",
                     e.cyc, e.d, e.b, e.is, e.wb, e.ov, e.dn, e.bz, e.row, e.it);
  endfunction

  // Monitor: full-state snapshots at requested cycles, then strobe events
  always @(negedge clk) begin
    ev_t o;
    while (qs.size() > 0 && int'(qs[0].cyc) <= cyc) begin
      o = obs(int'(qs[0].d), cyc);
      checks++;
      if (o !== qs[0]) begin
        failures++;
        $display("FAIL snapshot got {%s} want {%s}", fmt(o), fmt(qs[0]));
      end
      void'(qs.pop_front());
    end
    while (qe.size() > 0 && int'(qe[0].cyc) < cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_event got {none} want {%s}", fmt(qe[0]));
      void'(qe.pop_front());
    end
    for (int d = 0; d < 3; d++) begin
      o = obs(d, cyc);
      if (o.b | o.is | o.wb | o.ov | o.dn) begin
        checks++;
        if (qe.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event got {%s} want {none}", fmt(o));
        end else begin
          if (o !== qe[0]) begin
            failures++;
            $display("FAIL event got {%s} want {%s}", fmt(o), fmt(qe[0]));
          end
          void'(qe.pop_front());
        end
      end
    end
    if (cyc > 20000) begin
      checks++;
      failures++;
      $display("FAIL watchdog got cyc=%0d want finish before 20000", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
    if (fin) begin
      checks += 2;
      if (qe.size() != 0) begin
        failures++;
        $display("FAIL events_left got %0d want 0", qe.size());
      end
      if (qs.size() != 0) begin
        failures++;
        $display("FAIL snapshots_left got %0d want 0", qs.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_load(input int d, input int c0, input bit tog, output int last);
    int lc;
    lc = c0;
    for (int j = 0; j < 16; j++) begin
      lc = tog ? c0 + 2 * j : c0 + j;
      qe.push_back(mk(lc, d, 1, 0, 0, 0, 0, (j != 0), j, 0));
    end
    last = lc;
  endtask

  task automatic push_solve(input int d, input int s, input int lat, input int nk);
    int ti;
    for (int k = 0; k < nk; k++) begin
      ti = s + k * (lat + 1);
      if (lat == 0) begin
        qe.push_back(mk(ti, d, 0, 1, 1, 0, 0, 1, k % 16, k / 16));
      end else begin
        qe.push_back(mk(ti, d, 0, 1, 0, 0, 0, 1, k % 16, k / 16));
        qe.push_back(mk(ti + lat, d, 0, 0, 1, 0, 0, 1, k % 16, k / 16));
      end
    end
  endtask

  // Full solve on one instance; in_valid is held high after the load to
  // show it is ignored until the cycle of done
  task automatic run_solve(input int d, input int lat, input int nit, input bit tog,
                           input logic [3:0] rpat);
    int c0, last, s, o, c, h, dn;
    bit r;
    c0 = cyc;
    push_load(d, c0, tog, last);
    s = last + 1;
    push_solve(d, s, lat, 16 * nit);
    o = s + 16 * nit * (lat + 1);
    c = o;
    h = 0;
    while (h < 16) begin
      r = rpat[(c - o) % 4];
      qe.push_back(mk(c, d, 0, 0, r, 1, 0, 1, h, nit));
      if (r) h++;
      c++;
    end
    dn = c;
    qe.push_back(mk(dn, d, 0, 0, 0, 0, 1, 1, 15, nit));
    while (cyc <= dn) begin
      if (cyc <= last) iv[d] = tog ? ((cyc - c0) % 2 == 0) : 1'b1;
      else             iv[d] = (cyc < dn);
      rdy[d] = (cyc >= o && cyc < dn) ? rpat[(cyc - o) % 4] : 1'b0;
      step();
    end
    iv[d]  = 1'b0;
    rdy[d] = 1'b0;
    qs.push_back(mk(cyc, d, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    step();
  endtask

  // Reset asserted between clock edges while instance a waits on row 1 of
  // the second sweep
  task automatic reset_mid_wait();
    int c0, last, s, rc;
    c0 = cyc;
    push_load(0, c0, 1'b0, last);
    s = last + 1;
    push_solve(0, s, 2, 17);
    qe.push_back(mk(s + 51, 0, 0, 1, 0, 0, 0, 1, 1, 1));
    rc = s + 52;
    while (cyc < rc) begin
      iv[0] = 1'b1;
      step();
    end
    rst   = 1'b1;
    iv[0] = 1'b0;
    qs.push_back(mk(cyc, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    rst = 1'b0;
    step();
    qs.push_back(mk(cyc, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    step();
  endtask

  initial begin
    rst = 1'b1;
    iv  = '0;
    rdy = '0;
    step();
    for (int d = 0; d < 3; d++) qs.push_back(mk(cyc, d, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    rst = 1'b0;
    step();
    run_solve(1, 0, 2, 1'b0, 4'b1111);
    run_solve(2, 3, 1, 1'b0, 4'b1111);
    run_solve(0, 2, 2, 1'b1, 4'b1001);
    reset_mid_wait();
    fin = 1'b1;
  end

endmodule
